// File: rtl/dram_port_arbiter.sv
// Shares the DDR3 user command port between VGA, MCR, SDRAM and CPU-VRAM clients.
// Define DRAM_ARB_VGA_PRIO_EN to give VGA absolute priority over the round-robin group.
module dram_port_arbiter #(
  parameter logic [23:0] VRAM_BASE = 24'h400000,
  parameter logic [23:0] MCR_BASE  = 24'h500000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        calib_done,
  input  logic        vga_req,
  input  logic [14:0] vga_addr,
  output logic        vga_done,
  output logic [31:0] vga_rdata,
  input  logic        mcr_req,
  input  logic        mcr_write,
  input  logic [13:0] mcr_addr,
  input  logic [48:0] mcr_wdata,
  output logic        mcr_done,
  output logic [48:0] mcr_rdata,
  input  logic        sdram_req,
  input  logic        sdram_write,
  input  logic [21:0] sdram_addr,
  input  logic [31:0] sdram_wdata,
  output logic        sdram_done,
  output logic [31:0] sdram_rdata,
  input  logic        vcpu_req,
  input  logic        vcpu_write,
  input  logic [14:0] vcpu_addr,
  input  logic [31:0] vcpu_wdata,
  output logic        vcpu_done,
  output logic [31:0] vcpu_rdata,
  output logic        mem_cmd_valid,
  input  logic        mem_cmd_ready,
  output logic        mem_cmd_write,
  output logic [23:0] mem_cmd_addr,
  output logic [63:0] mem_wdata,
  input  logic        mem_rd_valid,
  input  logic [63:0] mem_rdata,
  output logic        busy
);

  // state   | meaning
  // IDLE    | arbitrate; latch winner's command when calibrated
  // ISSUE   | mem_cmd_valid high, waiting for mem_cmd_ready
  // WAIT_RD | read accepted, waiting for mem_rd_valid
  // DONE    | winner's done pulse; served client masked next IDLE
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_RD, S_DONE} state_t;

  localparam logic [1:0] ID_VGA   = 2'd0;
  localparam logic [1:0] ID_MCR   = 2'd1;
  localparam logic [1:0] ID_SDRAM = 2'd2;
  localparam logic [1:0] ID_VCPU  = 2'd3;

  state_t      state;
  logic [1:0]  cur_id;
  logic [1:0]  rr_ptr;
  logic [3:0]  mask;
  logic [3:0]  done_vec;
  logic [3:0]  req_m;
  logic [1:0]  c0, c1, c2;
  logic        grant_any;
  logic [1:0]  grant_id;
  logic        sel_write;
  logic [23:0] sel_addr;
  logic [63:0] sel_wdata;
  logic        unused_rdata_hi;

  assign unused_rdata_hi = ^mem_rdata[63:49];
  assign req_m = {vcpu_req, sdram_req, mcr_req, vga_req} & ~mask;

`ifdef DRAM_ARB_VGA_PRIO_EN
  localparam logic [1:0] RR_RESET = ID_MCR;

  function automatic logic [1:0] rr_next(input logic [1:0] id);
    return (id == ID_VCPU) ? ID_MCR : id + 2'd1;
  endfunction

  assign c0 = rr_ptr;
  assign c1 = rr_next(c0);
  assign c2 = rr_next(c1);

  always_comb begin
    grant_any = 1'b1;
    grant_id  = ID_VGA;
    if (req_m[ID_VGA])  grant_id = ID_VGA;
    else if (req_m[c0]) grant_id = c0;
    else if (req_m[c1]) grant_id = c1;
    else if (req_m[c2]) grant_id = c2;
    else                grant_any = 1'b0;
  end
`else
  localparam logic [1:0] RR_RESET = ID_VGA;
  logic [1:0] c3;

  function automatic logic [1:0] rr_next(input logic [1:0] id);
    return id + 2'd1;
  endfunction

  assign c0 = rr_ptr;
  assign c1 = rr_next(c0);
  assign c2 = rr_next(c1);
  assign c3 = rr_next(c2);

  always_comb begin
    grant_any = 1'b1;
    grant_id  = c0;
    if (req_m[c0])      grant_id = c0;
    else if (req_m[c1]) grant_id = c1;
    else if (req_m[c2]) grant_id = c2;
    else if (req_m[c3]) grant_id = c3;
    else                grant_any = 1'b0;
  end
`endif

  // Map the winner's client-local address/data into the flat DRAM word space.
  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    case (grant_id)
      ID_VGA: sel_addr = VRAM_BASE + {9'd0, vga_addr};
      ID_MCR: begin
        sel_write = mcr_write;
        sel_addr  = MCR_BASE + {10'd0, mcr_addr};
        sel_wdata = {15'd0, mcr_wdata};
      end
      ID_SDRAM: begin
        sel_write = sdram_write;
        sel_addr  = {2'b00, sdram_addr};
        sel_wdata = {32'd0, sdram_wdata};
      end
      default: begin
        sel_write = vcpu_write;
        sel_addr  = VRAM_BASE + {9'd0, vcpu_addr};
        sel_wdata = {32'd0, vcpu_wdata};
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      cur_id        <= ID_VGA;
      rr_ptr        <= RR_RESET;
      mask          <= '0;
      done_vec      <= '0;
      mem_cmd_valid <= 1'b0;
      mem_cmd_write <= 1'b0;
      mem_cmd_addr  <= '0;
      mem_wdata     <= '0;
      busy          <= 1'b0;
      vga_rdata     <= '0;
      mcr_rdata     <= '0;
      sdram_rdata   <= '0;
      vcpu_rdata    <= '0;
    end else begin
      done_vec <= '0;
      case (state)
        S_IDLE: begin
          mask <= '0;
          if (calib_done && grant_any) begin
            cur_id        <= grant_id;
            mem_cmd_write <= sel_write;
            mem_cmd_addr  <= sel_addr;
            mem_wdata     <= sel_wdata;
            mem_cmd_valid <= 1'b1;
            busy          <= 1'b1;
`ifdef DRAM_ARB_VGA_PRIO_EN
            if (grant_id != ID_VGA) rr_ptr <= rr_next(grant_id);
`else
            rr_ptr <= rr_next(grant_id);
`endif
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (mem_cmd_ready) begin
            mem_cmd_valid <= 1'b0;
            if (mem_cmd_write) begin
              done_vec <= 4'b0001 << cur_id;
              state    <= S_DONE;
            end else begin
              state <= S_WAIT_RD;
            end
          end
        end
        S_WAIT_RD: begin
          if (mem_rd_valid) begin
            case (cur_id)
              ID_VGA:   vga_rdata   <= mem_rdata[31:0];
              ID_MCR:   mcr_rdata   <= mem_rdata[48:0];
              ID_SDRAM: sdram_rdata <= mem_rdata[31:0];
              default:  vcpu_rdata  <= mem_rdata[31:0];
            endcase
            done_vec <= 4'b0001 << cur_id;
            state    <= S_DONE;
          end
        end
        default: begin
          mask  <= 4'b0001 << cur_id;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign vga_done   = done_vec[0];
  assign mcr_done   = done_vec[1];
  assign sdram_done = done_vec[2];
  assign vcpu_done  = done_vec[3];

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Directed bench for dram_port_arbiter: calibration gating, write/read paths,
// arbitration order, back-pressure and reset during an outstanding read.
module tb_dram_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        calib_done;
  logic        vga_req;
  logic [14:0] vga_addr;
  logic        vga_done;
  logic [31:0] vga_rdata;
  logic        mcr_req, mcr_write;
  logic [13:0] mcr_addr;
  logic [48:0] mcr_wdata;
  logic        mcr_done;
  logic [48:0] mcr_rdata;
  logic        sdram_req, sdram_write;
  logic [21:0] sdram_addr;
  logic [31:0] sdram_wdata;
  logic        sdram_done;
  logic [31:0] sdram_rdata;
  logic        vcpu_req, vcpu_write;
  logic [14:0] vcpu_addr;
  logic [31:0] vcpu_wdata;
  logic        vcpu_done;
  logic [31:0] vcpu_rdata;
  logic        mem_cmd_valid, mem_cmd_ready, mem_cmd_write;
  logic [23:0] mem_cmd_addr;
  logic [63:0] mem_wdata;
  logic        mem_rd_valid;
  logic [63:0] mem_rdata;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int rearm  = -1;
  int accepts;
  logic [3:0]  dv;
  logic [23:0] exp_addr [4];

  assign dv = {vcpu_done, sdram_done, mcr_done, vga_done};

  always #5 clk = ~clk;

  dram_port_arbiter dut (
    .clk(clk), .reset_n(reset_n), .calib_done(calib_done),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_done(vga_done), .vga_rdata(vga_rdata),
    .mcr_req(mcr_req), .mcr_write(mcr_write), .mcr_addr(mcr_addr), .mcr_wdata(mcr_wdata),
    .mcr_done(mcr_done), .mcr_rdata(mcr_rdata),
    .sdram_req(sdram_req), .sdram_write(sdram_write), .sdram_addr(sdram_addr),
    .sdram_wdata(sdram_wdata), .sdram_done(sdram_done), .sdram_rdata(sdram_rdata),
    .vcpu_req(vcpu_req), .vcpu_write(vcpu_write), .vcpu_addr(vcpu_addr),
    .vcpu_wdata(vcpu_wdata), .vcpu_done(vcpu_done), .vcpu_rdata(vcpu_rdata),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
    .mem_cmd_write(mem_cmd_write), .mem_cmd_addr(mem_cmd_addr), .mem_wdata(mem_wdata),
    .mem_rd_valid(mem_rd_valid), .mem_rdata(mem_rdata), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int id, input logic v);
    case (id)
      0:       vga_req   = v;
      1:       mcr_req   = v;
      2:       sdram_req = v;
      default: vcpu_req  = v;
    endcase
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 64'(mem_cmd_valid), 64'd0);
    chk({tag, "_write"}, 64'(mem_cmd_write), 64'd0);
    chk({tag, "_busy"},  64'(busy), 64'd0);
    chk({tag, "_done"},  64'(dv), 64'd0);
    chk({tag, "_addr"},  64'(mem_cmd_addr), 64'd0);
    chk({tag, "_wdata"}, mem_wdata, 64'd0);
    chk({tag, "_rdata"}, 64'(vga_rdata) | 64'(mcr_rdata) | 64'(sdram_rdata) | 64'(vcpu_rdata), 64'd0);
  endtask

  // One grant in the arbitration sequence; the served client drops req the
  // cycle after done and re-raises it after the next grant when keep is set.
  task automatic serve(input int id, input logic keep, input string tag);
    tick();
    chk({tag, "_valid"}, 64'(mem_cmd_valid), 64'd1);
    chk({tag, "_addr"},  64'(mem_cmd_addr), 64'(exp_addr[id]));
    chk({tag, "_write"}, 64'(mem_cmd_write), (id == 0) ? 64'd0 : 64'd1);
    if (rearm >= 0) set_req(rearm, 1'b1);
    tick();
    if (id == 0) begin
      mem_rd_valid = 1'b1;
      mem_rdata    = 64'hCAFE_0000_1357_9BDF;
      tick();
      mem_rd_valid = 1'b0;
      chk({tag, "_vga_rdata"}, 64'(vga_rdata), 64'h1357_9BDF);
    end
    chk({tag, "_done"}, 64'(dv), 64'(4'b0001 << id));
    tick();
    set_req(id, 1'b0);
    rearm = keep ? id : -1;
  endtask

  initial begin
    reset_n = 1'b0; calib_done = 1'b0;
    vga_req = 1'b0; vga_addr = '0;
    mcr_req = 1'b0; mcr_write = 1'b0; mcr_addr = '0; mcr_wdata = '0;
    sdram_req = 1'b0; sdram_write = 1'b0; sdram_addr = '0; sdram_wdata = '0;
    vcpu_req = 1'b0; vcpu_write = 1'b0; vcpu_addr = '0; vcpu_wdata = '0;
    mem_cmd_ready = 1'b0; mem_rd_valid = 1'b0; mem_rdata = '0;

    repeat (2) tick();
    chk_all_zero("reset");
    reset_n = 1'b1;
    tick();

    // Calibration gating with an SDRAM write pending
    sdram_req = 1'b1; sdram_write = 1'b1; sdram_addr = 22'h12345; sdram_wdata = 32'hDEADBEEF;
    mem_cmd_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("calib_gate_valid", 64'(mem_cmd_valid), 64'd0);
    end
    calib_done = 1'b1;
    tick();
    chk("wr_valid", 64'(mem_cmd_valid), 64'd1);
    chk("wr_busy",  64'(busy), 64'd1);
    chk("wr_addr",  64'(mem_cmd_addr), 64'h012345);
    chk("wr_wdata", mem_wdata, 64'h0000_0000_DEAD_BEEF);
    chk("wr_write", 64'(mem_cmd_write), 64'd1);
    tick();
    chk("wr_done",       64'(dv), 64'b0100);
    chk("wr_valid_drop", 64'(mem_cmd_valid), 64'd0);
    tick();
    chk("wr_done_end", 64'(dv), 64'd0);
    chk("wr_idle_busy", 64'(busy), 64'd0);
    sdram_req = 1'b0;
    tick();
    chk("wr_no_regrant", 64'(mem_cmd_valid), 64'd0);

    // MCR read, data returned 5 cycles after accept
    mcr_req = 1'b1; mcr_write = 1'b0; mcr_addr = 14'h0010; mcr_wdata = 49'h1_FFFF_FFFF_FFFF;
    tick();
    chk("rd_valid", 64'(mem_cmd_valid), 64'd1);
    chk("rd_addr",  64'(mem_cmd_addr), 64'h500010);
    chk("rd_write", 64'(mem_cmd_write), 64'd0);
    tick();
    chk("rd_accept", 64'(mem_cmd_valid), 64'd0);
    repeat (4) tick();
    chk("rd_wait_done", 64'(dv), 64'd0);
    chk("rd_wait_busy", 64'(busy), 64'd1);
    mem_rd_valid = 1'b1; mem_rdata = 64'h0001_2345_6789_ABCD;
    tick();
    mem_rd_valid = 1'b0;
    chk("rd_done",  64'(dv), 64'b0010);
    chk("rd_rdata", 64'(mcr_rdata), 64'h1_2345_6789_ABCD);
    tick();
    chk("rd_done_end", 64'(dv), 64'd0);
    mcr_req = 1'b0;

    // Stray read data in IDLE is ignored
    mem_rd_valid = 1'b1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    mem_rd_valid = 1'b0;
    chk("stray_rdata", 64'(mcr_rdata), 64'h1_2345_6789_ABCD);
    chk("stray_done",  64'(dv), 64'd0);
    chk("stray_busy",  64'(busy), 64'd0);

    // Reset while a read is outstanding
    mcr_req = 1'b1; mcr_addr = 14'h0033;
    tick();
    tick();
    chk("rst_mid_busy", 64'(busy), 64'd1);
    reset_n = 1'b0;
    #2;
    chk_all_zero("rst_mid");
    reset_n = 1'b1;
    mcr_req = 1'b0;
    tick();
    mem_rd_valid = 1'b1; mem_rdata = 64'h0000_1111_2222_3333;
    tick();
    mem_rd_valid = 1'b0;
    chk_all_zero("rst_late_rd");

    // Normal service after reset, top of VRAM window
    vcpu_req = 1'b1; vcpu_write = 1'b0; vcpu_addr = 15'h7FFF;
    tick();
    chk("post_rst_valid", 64'(mem_cmd_valid), 64'd1);
    chk("post_rst_addr",  64'(mem_cmd_addr), 64'h407FFF);
    tick();
    mem_rd_valid = 1'b1; mem_rdata = 64'hFFFF_FFFF_1234_5678;
    tick();
    mem_rd_valid = 1'b0;
    chk("post_rst_done",  64'(dv), 64'b1000);
    chk("post_rst_rdata", 64'(vcpu_rdata), 64'h1234_5678);
    tick();
    vcpu_req = 1'b0;

    // Arbitration: MCR/SDRAM/VCPU writes held continuously
    vga_addr = 15'h0100; mcr_addr = 14'h0020; sdram_addr = 22'h000300; vcpu_addr = 15'h0040;
    mcr_write = 1'b1; sdram_write = 1'b1; vcpu_write = 1'b1;
    exp_addr[0] = 24'h400100; exp_addr[1] = 24'h500020;
    exp_addr[2] = 24'h000300; exp_addr[3] = 24'h400040;
    mcr_req = 1'b1; sdram_req = 1'b1; vcpu_req = 1'b1;
    serve(1, 1'b1, "arb0_mcr");
    serve(2, 1'b1, "arb1_sdram");
    serve(3, 1'b1, "arb2_vcpu");
    serve(1, 1'b1, "arb3_mcr");
    vga_req = 1'b1;
`ifdef DRAM_ARB_VGA_PRIO_EN
    serve(0, 1'b0, "arb4_vga");
    serve(2, 1'b1, "arb5_sdram");
    serve(3, 1'b1, "arb6_vcpu");
`else
    serve(2, 1'b1, "arb4_sdram");
    serve(3, 1'b1, "arb5_vcpu");
    serve(0, 1'b0, "arb6_vga");
`endif
    vga_req = 1'b0; mcr_req = 1'b0; sdram_req = 1'b0; vcpu_req = 1'b0;
    rearm = -1;
    tick();
    chk("arb_quiet_valid", 64'(mem_cmd_valid), 64'd0);
    chk("arb_quiet_busy",  64'(busy), 64'd0);

    // Back-pressure: ready low for 10 ISSUE cycles
    accepts = 0;
    mem_cmd_ready = 1'b0;
    sdram_req = 1'b1; sdram_write = 1'b1; sdram_addr = 22'h3FFFFF; sdram_wdata = 32'hA5A5_5A5A;
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", 64'(mem_cmd_valid), 64'd1);
      chk("bp_addr",  64'(mem_cmd_addr), 64'h3FFFFF);
      chk("bp_wdata", mem_wdata, 64'h0000_0000_A5A5_5A5A);
      chk("bp_write", 64'(mem_cmd_write), 64'd1);
      if (mem_cmd_valid && mem_cmd_ready) accepts++;
      tick();
    end
    mem_cmd_ready = 1'b1;
    #1;
    if (mem_cmd_valid && mem_cmd_ready) accepts++;
    tick();
    chk("bp_done", 64'(dv), 64'b0100);
    tick();
    sdram_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (mem_cmd_valid && mem_cmd_ready) accepts++;
      tick();
    end
    chk("bp_accepts", 64'(accepts), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
